// File: rtl/ysyx_22041752_div_pkg.sv
// Shared width, state encoding and two's-complement helper for the
// iterative RV64M divider.
package ysyx_22041752_div_pkg;

  localparam int WIDTH = 64;
  localparam int CNT_W = 7;

  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ysyx_22041752_aser.sv
// Generic adder/subtractor; with sub_i=1 computes a_i-b_i and cout_o=1
// means no borrow occurred.
module ysyx_22041752_aser #(
  parameter int W = 65
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i ^ {W{sub_i}}} + {{W{1'b0}}, sub_i};

endmodule

// File: rtl/ysyx_22041752_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle, with divide-by-zero and signed overflow resolved at request time.
module ysyx_22041752_div
  import ysyx_22041752_div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             div_valid,
  input  logic             div_u,
  input  logic             div_r,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             out_valid
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             rsel_q, rsel_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic             no_borrow_s;
  logic             unused_trial_msb_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_abs_s, b_abs_s;
  logic             div_zero_s, ovf_s;

  assign a_neg_s    = !div_u && dividend[WIDTH-1];
  assign b_neg_s    = !div_u && divisor[WIDTH-1];
  assign a_abs_s    = a_neg_s ? neg2c(dividend) : dividend;
  assign b_abs_s    = b_neg_s ? neg2c(divisor) : divisor;
  assign div_zero_s = (divisor == {WIDTH{1'b0}});
  assign ovf_s      = !div_u && (dividend == MIN_VAL) && (divisor == {WIDTH{1'b1}});

  // The shifted partial remainder is WIDTH+1 bits so |MIN| divides correctly.
  assign shifted_s = {rem_q, quo_q[WIDTH-1]};

  ysyx_22041752_aser #(.W(WIDTH + 1)) u_trial (
    .a_i   (shifted_s),
    .b_i   ({1'b0, dsr_q}),
    .sub_i (1'b1),
    .sum_o (trial_s),
    .cout_o(no_borrow_s)
  );

  // A non-borrowing trial is always below the divisor, so its top bit is zero.
  assign unused_trial_msb_s = trial_s[WIDTH];

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    result_d    = result_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    rsel_d      = rsel_q;
    out_valid_d = 1'b0;
    if (flush || !div_valid) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rsel_d  = div_r;
          dsr_d   = b_abs_s;
          count_d = {CNT_W{1'b0}};
          if (div_zero_s) begin
            quo_d   = {WIDTH{1'b1}};
            rem_d   = dividend;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = ST_DONE;
          end else if (ovf_s) begin
            quo_d   = MIN_VAL;
            rem_d   = {WIDTH{1'b0}};
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            quo_d   = a_abs_s;
            rem_d   = {WIDTH{1'b0}};
            q_neg_d = a_neg_s ^ b_neg_s;
            r_neg_d = a_neg_s;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          rem_d   = no_borrow_s ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
          quo_d   = {quo_q[WIDTH-2:0], no_borrow_s};
          count_d = count_q + 7'd1;
          if (count_q == LAST_STEP) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (rsel_q) begin
            result_d = r_neg_q ? neg2c(rem_q) : rem_q;
          end else begin
            result_d = q_neg_q ? neg2c(quo_q) : quo_q;
          end
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= {CNT_W{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dsr_q       <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      rsel_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      result_q    <= result_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      rsel_q      <= rsel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ysyx_22041752_div.sv
// Scoreboard bench for ysyx_22041752_div: directed RISC-V corner cases,
// flush/reset aborts, and random operands against a behavioural model.
module tb_ysyx_22041752_div;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        div_valid;
  logic        div_u;
  logic        div_r;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic [63:0] result;
  logic        out_valid;

  int          total;
  int          bad;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [63:0] last_exp;

  ysyx_22041752_div dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .div_valid(div_valid),
    .div_u    (div_u),
    .div_r    (div_r),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] golden(input logic u, input logic r,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = a;
    sb = b;
    if (b == 64'd0) return r ? a : ONES;
    if (!u && a == MIN64 && b == ONES) return r ? 64'd0 : MIN64;
    if (u) return r ? (a % b) : (a / b);
    return r ? 64'(sa % sb) : 64'(sa / sb);
  endfunction

  function automatic int golden_lat(input logic u, input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return 1;
    if (!u && a == MIN64 && b == ONES) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return ONES;
      3:       return MIN64;
      4:       return MAX64;
      5:       return 64'($urandom_range(0, 100));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive(input logic u, input logic r, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    div_u     = u;
    div_r     = r;
    dividend  = a;
    divisor   = b;
    div_valid = 1'b1;
  endtask

  // cyc is 0 right after the edge that first samples the request.
  task automatic run_op(input string tag, input logic u, input logic r,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    int          cyc;
    logic        seen;
    logic [63:0] e;
    int          l;
    drive(u, r, a, b);
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    cyc  = -1;
    seen = 1'b0;
    while (!seen && cyc < 150) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = out_valid;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (!seen) begin
      check_val({tag, "_timeout"}, 64'(out_valid), 64'd1);
    end else begin
      check_val({tag, "_res"}, result, e);
      check_val({tag, "_lat"}, 64'(cyc), 64'(l));
      last_exp = e;
    end
    @(negedge clk);
    div_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int          pulses;
    logic        u;
    logic        r;
    logic [63:0] a;
    logic [63:0] b;
    total     = 0;
    bad       = 0;
    last_exp  = 64'd0;
    reset     = 1'b0;
    flush     = 1'b0;
    div_valid = 1'b1;
    div_u     = 1'b1;
    div_r     = 1'b0;
    dividend  = 64'd5;
    divisor   = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_result", result, 64'd0);
    check_val("rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    div_valid = 1'b0;
    reset     = 1'b1;

    run_op("divu_100_7", 1'b1, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu_100_7", 1'b1, 1'b1, 64'd100, 64'd7, 64'd2, 65);
    run_op("div_m7_2", 1'b0, 1'b0, -64'sd7, 64'd2, -64'sd3, 65);
    run_op("rem_m7_2", 1'b0, 1'b1, -64'sd7, 64'd2, -64'sd1, 65);
    run_op("rem_7_m2", 1'b0, 1'b1, 64'd7, -64'sd2, 64'd1, 65);
    run_op("div_m8_m2", 1'b0, 1'b0, -64'sd8, -64'sd2, 64'd4, 65);
    run_op("div_5_0", 1'b0, 1'b0, 64'd5, 64'd0, ONES, 1);
    run_op("rem_5_0", 1'b0, 1'b1, 64'd5, 64'd0, 64'd5, 1);
    run_op("div_ovf", 1'b0, 1'b0, MIN64, ONES, MIN64, 1);
    run_op("rem_ovf", 1'b0, 1'b1, MIN64, ONES, 64'd0, 1);
    run_op("div_0_5", 1'b0, 1'b0, 64'd0, 64'd5, 64'd0, 65);
    run_op("divu_min_ones", 1'b1, 1'b0, MIN64, ONES, 64'd0, 65);
    run_op("div_min_1", 1'b0, 1'b0, MIN64, 64'd1, MIN64, 65);
    run_op("divu_ones_1", 1'b1, 1'b0, ONES, 64'd1, ONES, 65);

    // Flush mid-operation at count 30.
    drive(1'b1, 1'b0, 64'd100, 64'd7);
    repeat (31) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check_val("flush30_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush     = 1'b0;
    div_valid = 1'b0;
    pulses    = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check_val("flush30_pulses", 64'(pulses), 64'd0);
    check_val("flush30_hold", result, last_exp);
    run_op("divu_9_3", 1'b1, 1'b0, 64'd9, 64'd3, 64'd3, 65);

    // Flush in the completion cycle itself.
    drive(1'b1, 1'b0, 64'd100, 64'd7);
    repeat (65) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check_val("flushdone_valid", 64'(out_valid), 64'd0);
    check_val("flushdone_hold", result, last_exp);
    @(negedge clk);
    flush     = 1'b0;
    div_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("flushdone_after", 64'(out_valid), 64'd0);

    // Reset mid-operation at count 10.
    drive(1'b0, 1'b0, 64'd1000, 64'd3);
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst10_valid", 64'(out_valid), 64'd0);
    check_val("rst10_result", result, 64'd0);
    last_exp = 64'd0;
    @(negedge clk);
    reset     = 1'b1;
    div_valid = 1'b0;
    run_op("div_7_m2", 1'b0, 1'b0, 64'd7, -64'sd2, -64'sd3, 65);

    for (int i = 0; i < 60; i++) begin
      u = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      run_op("rand", u, r, a, b, golden(u, r, a, b), golden_lat(u, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
